// File: rtl/if_control.sv
// if_control: instruction-fetch sequencing controller.
// Merges hazard stalls, control-flow requests and interrupt/exception entry
// into fetch-stage controls. Owns the entry state machine and the saved epc.
module if_control (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        irq,
   input  logic        exc,
   input  logic        load_use,
   input  logic        mem_wait,
   input  logic        branch_taken,
   input  logic        is_j,
   input  logic        is_jr,
   input  logic        eret,
   input  logic [31:0] resume_pc,
   output logic        PC_IF_ID_Write,
   output logic [2:0]  select_PC_next,
   output logic [1:0]  status,
   output logic [31:0] epc,
   output logic        double_fault
);

   typedef enum logic [1:0] {RUN = 2'd0, ENTER = 2'd1, KERNEL = 2'd2} state_t;

   state_t state;
   logic   pend_exc;
   logic   pend_irq;
   logic   stall;
   logic   safe;
   logic   entry_req;

   assign stall     = load_use | mem_wait;
   // Entry may only happen when no control transfer is in flight, so that
   // resume_pc is an unambiguous return address.
   assign safe      = ~stall & ~branch_taken & ~is_j & ~is_jr;
   assign entry_req = pend_exc | pend_irq | exc | irq;

   // The fetch stage advances whenever no hazard holds it, in every state.
   assign PC_IF_ID_Write = ~stall;

   // Next-PC select: suppressed while stalled or while the vector is loading.
   always_comb begin
      select_PC_next = 3'b000;
      if (!stall && state != ENTER) begin
         if (branch_taken)  select_PC_next = 3'b100;
         else if (is_j)     select_PC_next = 3'b010;
         else if (is_jr)    select_PC_next = 3'b001;
      end
   end

   // Entry FSM with registered status, pendings, epc and sticky double fault.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= RUN;
         pend_exc     <= 1'b0;
         pend_irq     <= 1'b0;
         epc          <= 32'h8000_0000;
         double_fault <= 1'b0;
         status       <= 2'b00;
      end else begin
         case (state)
            RUN: begin
               pend_exc <= pend_exc | exc;
               pend_irq <= pend_irq | irq;
               if (entry_req && safe) begin
                  state  <= ENTER;
                  epc    <= resume_pc;
                  // Exception wins; a coincident interrupt is dropped.
                  status <= (pend_exc | exc) ? 2'b01 : 2'b10;
               end
            end
            ENTER: begin
               if (!stall) begin
                  state    <= KERNEL;
                  status   <= 2'b00;
                  pend_exc <= 1'b0;
                  pend_irq <= 1'b0;
               end
            end
            KERNEL: begin
               if (exc) double_fault <= 1'b1;
               if (eret && is_jr && !stall) state <= RUN;
            end
            default: begin
               state  <= RUN;
               status <= 2'b00;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_if_control.sv
// tb_if_control: randomized scoreboard bench for if_control.
module tb_if_control;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        irq = 1'b0, exc = 1'b0, load_use = 1'b0, mem_wait = 1'b0;
   logic        branch_taken = 1'b0, is_j = 1'b0, is_jr = 1'b0, eret = 1'b0;
   logic [31:0] resume_pc = 32'h0;
   logic        PC_IF_ID_Write;
   logic [2:0]  select_PC_next;
   logic [1:0]  status;
   logic [31:0] epc;
   logic        double_fault;

   if_control dut (
      .clk(clk), .rst_n(rst_n), .irq(irq), .exc(exc), .load_use(load_use),
      .mem_wait(mem_wait), .branch_taken(branch_taken), .is_j(is_j),
      .is_jr(is_jr), .eret(eret), .resume_pc(resume_pc),
      .PC_IF_ID_Write(PC_IF_ID_Write), .select_PC_next(select_PC_next),
      .status(status), .epc(epc), .double_fault(double_fault)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic [2:0]  sel;
      logic [1:0]  st;
      logic [31:0] epc;
      logic        df;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad = 0;
   bit   done = 0;

   // Reference model: where the processor is in handling an event.
   // mode: "user" running, "vectoring" (fetch loads handler), "handler".
   string       mode = "user";
   bit          want_exc = 0, want_irq = 0;
   logic [1:0]  entry_kind = 2'b00;
   logic [31:0] m_epc = 32'h8000_0000;
   bit          m_df = 0;

   task automatic model_reset();
      mode = "user"; want_exc = 0; want_irq = 0; entry_kind = 2'b00;
      m_epc = 32'h8000_0000; m_df = 0;
   endtask

   task automatic step(input bit r, input bit lu, input bit mw, input bit br,
                       input bit j, input bit jr, input bit er, input bit iq,
                       input bit ex, input logic [31:0] rpc);
      exp_t e;
      bit stall;
      @(negedge clk);
      #1;
      rst_n = r; load_use = lu; mem_wait = mw; branch_taken = br; is_j = j;
      is_jr = jr | er; eret = er; irq = iq; exc = ex; resume_pc = rpc;
      if (!r) model_reset();
      stall = lu | mw;
      e.wr  = !stall;
      if (stall || mode == "vectoring") e.sel = 3'b000;
      else if (br)                      e.sel = 3'b100;
      else if (j)                       e.sel = 3'b010;
      else if (jr | er)                 e.sel = 3'b001;
      else                              e.sel = 3'b000;
      e.st  = (mode == "vectoring") ? entry_kind : 2'b00;
      e.epc = m_epc;
      e.df  = m_df;
      q.push_back(e);
      if (r) begin
         if (mode == "user") begin
            if ((want_exc | want_irq | ex | iq) && !stall && !br && !j && !(jr | er)) begin
               entry_kind = (want_exc | ex) ? 2'b01 : 2'b10;
               m_epc = rpc;
               mode = "vectoring";
               want_exc = 0; want_irq = 0;
            end else begin
               want_exc |= ex; want_irq |= iq;
            end
         end else if (mode == "vectoring") begin
            if (!stall) mode = "handler";
         end else begin
            if (ex) m_df = 1;
            if (er && !stall) mode = "user";
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Stimulus: directed walk through the scenarios, then random traffic.
   initial begin
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
      idle(2);
      step(1, 1, 0, 1, 0, 0, 0, 0, 0, 32'h0);      // load_use with branch
      step(1, 0, 0, 1, 0, 0, 0, 0, 0, 32'h0);      // branch held, no stall
      step(1, 0, 0, 0, 0, 0, 0, 1, 0, 32'h40);     // irq in safe cycle
      step(1, 0, 0, 0, 0, 0, 0, 1, 0, 32'h44);     // ENTER, irq still high
      step(1, 0, 0, 0, 0, 0, 0, 1, 0, 32'h48);     // KERNEL, irq masked
      step(1, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0);      // eret back to RUN
      step(1, 0, 1, 0, 0, 0, 0, 1, 1, 32'h100);    // exc+irq while stalled
      step(1, 0, 1, 0, 0, 0, 0, 0, 0, 32'h104);
      step(1, 0, 1, 0, 0, 0, 0, 0, 0, 32'h108);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h10c);    // safe: enter with 01
      step(1, 0, 1, 0, 0, 0, 0, 0, 0, 32'h0);      // ENTER stalled twice
      step(1, 0, 1, 0, 0, 0, 0, 0, 0, 32'h0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);      // -> KERNEL
      step(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0);      // double fault
      step(1, 1, 0, 0, 0, 0, 1, 0, 0, 32'h0);      // eret held off by stall
      step(1, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0);      // eret -> RUN
      step(1, 0, 0, 0, 0, 0, 0, 1, 0, 32'h200);    // irq accepted again
      idle(2);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);      // reset mid-KERNEL
      idle(2);
      for (int i = 0; i < 3000; i++) begin
         bit r, lu, mw, br, j, jr, er, iq, ex;
         r  = ($urandom_range(0, 199) != 0);
         lu = ($urandom_range(0, 9) == 0);
         mw = ($urandom_range(0, 7) == 0);
         br = ($urandom_range(0, 9) == 0);
         j  = ($urandom_range(0, 11) == 0);
         jr = ($urandom_range(0, 11) == 0);
         er = ($urandom_range(0, 9) == 0);
         iq = ($urandom_range(0, 7) == 0);
         ex = ($urandom_range(0, 19) == 0);
         step(r, lu, mw, br, j, jr, er, iq, ex, $urandom);
      end
      @(negedge clk);
      done = 1;
   end

   // Monitor: every cycle the DUT presents a settled output set; check it.
   initial begin
      exp_t e;
      while (!(done && q.size() == 0)) begin
         @(negedge clk);
         #2;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("write",        {31'h0, PC_IF_ID_Write}, {31'h0, e.wr});
            chk("select",       {29'h0, select_PC_next}, {29'h0, e.sel});
            chk("status",       {30'h0, status},         {30'h0, e.st});
            chk("epc",          epc,                     e.epc);
            chk("double_fault", {31'h0, double_fault},   {31'h0, e.df});
         end
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/if_control.md
# if_control

Sequencing controller for the instruction-fetch stage. It merges hazard stalls, resolved control-flow requests and interrupt/exception entry into the three control inputs of the fetch stage: PC/IF_ID write enable, one-hot next-PC select and entry status. It owns the interrupt-entry state machine and the exception PC (epc), and sits between decode/hazard logic and the fetch stage.

## Interface
- No parameters. Handler vectors are fixed in the fetch stage: 0x8000_0004 for interrupt, 0x8000_0008 for exception.
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  asynchronous reset, active low
- irq  in  1  level interrupt request from peripherals
- exc  in  1  one-cycle exception pulse (illegal opcode, overflow)
- load_use  in  1  load-use hazard from decode; stall one cycle
- mem_wait  in  1  memory not ready; stall while high
- branch_taken  in  1  branch resolved taken
- is_j  in  1  decoded j/jal
- is_jr  in  1  decoded jr/jalr (includes eret)
- eret  in  1  decoded eret; always accompanied by is_jr
- resume_pc  in  32  address to return to if entry occurs this cycle
- PC_IF_ID_Write  out  1  fetch-stage write enable
- select_PC_next  out  3  {branch, jump, jr}, one-hot or 000
- status  out  2  {interrupt, exception} entry request
- epc  out  32  saved return address; source for the eret jr target
- double_fault  out  1  sticky: exception raised while in kernel

## Operation
- stall = load_use | mem_wait.
- PC_IF_ID_Write = ~stall, in every state.
- select_PC_next:
  - 000 when stall or state ENTER.
  - Otherwise priority branch_taken > is_j > is_jr, giving 100 / 010 / 001.
  - Never more than one bit set.
- Pending flags:
  - pend_exc is set by exc in RUN.
  - pend_irq is set by irq in RUN.
  - Both clear on the edge leaving ENTER.
- safe = ~stall & ~branch_taken & ~is_j & ~is_jr.
- States:
  - RUN: interrupts enabled; status = 00.
    - If (pend_exc | pend_irq | exc | irq) & safe → ENTER; epc <= resume_pc on that edge.
    - Otherwise stay in RUN, latching pendings.
  - ENTER:
    - status = 01 if an exception is pending, else 10. Exception has priority over interrupt; a simultaneous interrupt is dropped, not deferred.
    - Stays in ENTER while stall, holding status; the fetch stage does not move.
    - First non-stall cycle → KERNEL.
  - KERNEL: status = 00; irq is ignored (masked, not latched).
    - exc sets double_fault, which stays set until reset; the state does not change.
    - eret & is_jr & ~stall → RUN on that edge. eret while stalled is held off until the stall clears.
- Branch/jump requests arriving while stalled are not remembered. The requesting stage is stalled too and must hold its request.
- epc changes only on the RUN→ENTER edge.

## Timing
- PC_IF_ID_Write and select_PC_next are combinational from inputs and state: same-cycle response, no latency.
- status is Moore (decoded from the state register only). It is valid for the whole ENTER cycle, and the fetch stage loads the vector PC on the edge ending it.
- Entry latency: a request in a safe RUN cycle gives ENTER in the next cycle and the handler PC one cycle later. Each unsafe cycle adds one cycle.
- Reset values:
  - state = RUN; pend_exc = pend_irq = 0.
  - epc = 0x8000_0000; double_fault = 0.
  - status = 00; select_PC_next = 000 (given inputs low); PC_IF_ID_Write = 1 (given stalls low).
- Reset asserted mid-ENTER or mid-KERNEL returns immediately to RUN and clears the pendings; no entry is completed.
- exc and irq in the same safe cycle: one ENTER with status 01.

## Test plan
- Reset, then idle inputs → status 00, select 000, write 1, epc 0x8000_0000, double_fault 0.
- load_use high 1 cycle together with branch_taken → that cycle write 0 and select 000; next cycle with branch_taken held → select 100, write 1.
- irq pulse in a safe cycle with resume_pc = 0x0000_0040 → next cycle status 10 and epc 0x0000_0040; the following cycle status 00 and irq masked.
- exc and irq together while mem_wait is high for 3 cycles → entry is deferred while stalled. Once safe, ENTER with status 01.
- In ENTER, mem_wait high for 2 cycles → status holds 01 and write holds 0 for 2 cycles, then KERNEL.
- In KERNEL:
  - exc → double_fault 1, state unchanged.
  - eret + is_jr → select 001, back to RUN; a later irq is accepted again.
  - Reset mid-KERNEL → RUN with all outputs at reset values.
